pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter INST_W, default 32, instruction field width.
REQ-002 SHALL have parameter PC_W, default 32, program-counter field width.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the bubble encoding.
REQ-004 SHALL have parameter CNT_W, default 16, flush-counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat present.
REQ-008 SHALL have port in_ready, output, 1, stage can accept a beat; registered, no combinational path from any input.
REQ-009 SHALL have port in_inst, input, INST_W, upstream instruction.
REQ-010 SHALL have port in_pc, input, PC_W, upstream PC.
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream can accept.
REQ-013 SHALL have port out_inst, output, INST_W, head instruction, or NOP_INST when out_valid=0.
REQ-014 SHALL have port out_pc, output, PC_W, head PC; holds last value when out_valid=0.
REQ-015 SHALL have port stall, input, 1, hazard hold; blocks the downstream pop.
REQ-016 SHALL have port flush, input, 1, kill all in-flight beats.
REQ-017 SHALL have port occupancy, output, 2, number of valid entries (0..2).
REQ-018 SHALL have port flush_cnt, output, CNT_W, saturating count of effective flushes.

Function
REQ-019 SHALL hold two entries: main (drives out_*) and skid; FIFO order, main older.
REQ-020 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready & ~stall.
REQ-021 SHALL drive in_ready = ~skid_valid from a flop, giving full throughput with a registered upstream ready.
REQ-022 SHALL present a pushed beat on out_* one cycle after the push when main was empty or popped in the same cycle.
REQ-023 SHALL write a push into skid when main is valid and not popped.
REQ-024 SHALL move skid into main on pop when skid is valid; push cannot coincide because in_ready=0.
REQ-025 SHALL sustain one beat per cycle with out_ready=1 and stall=0 (occupancy stays 1).
REQ-026 SHALL hold main and skid contents unchanged while stall=1, regardless of out_ready.
REQ-027 SHALL, on flush, clear main and skid valid and discard any same-cycle push; flush overrides stall and pop.
REQ-028 SHALL drive out_valid=0, out_inst=NOP_INST and in_ready=1 in the cycle after a flush.
REQ-029 SHALL keep out_pc at its pre-flush value after a flush.
REQ-030 SHALL increment flush_cnt when flush=1 and occupancy!=0, saturating at all-ones with no wrap.
REQ-031 SHALL leave out_* unchanged while in_valid=0 and no pop occurs.

Reset
REQ-032 SHALL, while rst=1, set out_valid=0, skid_valid=0, in_ready=1, out_inst=NOP_INST, out_pc=0, occupancy=0 and flush_cnt=0.
REQ-033 SHALL give rst priority over flush, stall, push and pop; a beat presented during reset is dropped.
REQ-034 SHALL accept a push in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place NOP_INST, the default widths and the entry record type (valid, inst, pc) in the shared package riscv_pipe_pkg.
REQ-036 SHALL implement each storage slot as an instance of sub-module pipe_entry (load, clear, hold).

Verification
REQ-037 Streaming: push PCs 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> out_pc reads 0x100, 0x104, 0x108 one cycle later each, and in_ready stays 1.
REQ-038 Backpressure: out_ready=0 while pushing 0x200 then 0x204 -> occupancy=2, in_ready=0; then out_ready=1 -> 0x200 then 0x204 are delivered in order with no loss or duplication.
REQ-039 Stall: occupancy=1 with head 0x300, stall=1 and out_ready=1 for 3 cycles -> out_pc=0x300 and out_valid=1 are held throughout, and 0x300 pops on the first cycle after stall drops.
REQ-040 Flush: occupancy=2, flush=1 with in_valid=1 and in_pc=0x400 -> next cycle out_valid=0, out_inst=0x00000013, occupancy=0, flush_cnt=1, and 0x400 is never delivered.
REQ-041 Saturation and reset: with CNT_W=2, five flushes each with occupancy>0 -> flush_cnt=3; then rst=1 for one cycle with in_valid=1 -> all REQ-032 values hold and nothing is delivered.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline register slices.
// Holds the bubble encoding, the default field widths and the entry record.
package riscv_pipe_pkg;

  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_CNT_W  = 16;

  // addi x0,x0,0
  localparam logic [DEF_INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_PC_W-1:0]   pc;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the skid stage: load, clear (drop valid, keep data), or hold.
// The PC is kept on clear so the stage can keep presenting the last PC.
module pipe_entry
  import riscv_pipe_pkg::*;
#(
  parameter int                INST_W   = DEF_INST_W,
  parameter int                PC_W     = DEF_PC_W,
  parameter logic [INST_W-1:0] RST_INST = NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] d_inst,
  input  logic [PC_W-1:0]   d_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc
);

  // Clear wins over load so a flush always empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= RST_INST;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register with registered upstream ready,
// hazard stall, flush and a saturating count of effective flushes.
module pipe_stage_skid #(
  parameter int                INST_W   = riscv_pipe_pkg::DEF_INST_W,
  parameter int                PC_W     = riscv_pipe_pkg::DEF_PC_W,
  parameter logic [INST_W-1:0] NOP_INST = riscv_pipe_pkg::NOP_INST,
  parameter int                CNT_W    = riscv_pipe_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_valid;
  logic [INST_W-1:0] main_inst;
  logic [PC_W-1:0]   main_pc;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;

  logic              push;
  logic              pop;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [INST_W-1:0] main_d_inst;
  logic [PC_W-1:0]   main_d_pc;

  // in_ready is a pure function of the skid flop, so upstream never sees an input-to-ready path.
  assign in_ready = ~skid_valid;
  assign push     = in_valid & in_ready;
  assign pop      = main_valid & out_ready & ~stall;

  // A push can only land in main when skid is empty, so skid is always the refill source when valid.
  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_d_inst = skid_valid ? skid_inst : in_inst;
    main_d_pc   = skid_valid ? skid_pc   : in_pc;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      main_load  = (pop & skid_valid) | (push & (~main_valid | pop));
      main_clear = pop & ~main_load;
      skid_load  = push & main_valid & ~pop;
      skid_clear = pop & skid_valid;
    end
  end

  pipe_entry #(
    .INST_W   (INST_W),
    .PC_W     (PC_W),
    .RST_INST (NOP_INST)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_inst (main_d_inst),
    .d_pc   (main_d_pc),
    .valid  (main_valid),
    .inst   (main_inst),
    .pc     (main_pc)
  );

  pipe_entry #(
    .INST_W   (INST_W),
    .PC_W     (PC_W),
    .RST_INST (NOP_INST)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_inst (in_inst),
    .d_pc   (in_pc),
    .valid  (skid_valid),
    .inst   (skid_inst),
    .pc     (skid_pc)
  );

  assign out_valid = main_valid;
  assign out_inst  = main_valid ? main_inst : NOP_INST;
  assign out_pc    = main_pc;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Flushes of an already empty stage are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (flush && (occupancy != 2'd0) && (flush_cnt != {CNT_W{1'b1}})) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid with a 2-bit flush counter.
// Inputs change #1 after the rising edge; outputs are checked at that same point.
module tb_pipe_stage_skid;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              stall;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .INST_W   (INST_W),
    .PC_W     (PC_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc,
                               input logic ordy, input logic stl, input logic fl);
    rst       = r;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = 32'hA000_0000 | pc;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [1:0] occ, input logic rdy);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    checkOutput({tag, ".out_inst"},  64'(out_inst),  64'(inst));
    checkOutput({tag, ".out_pc"},    64'(out_pc),    64'(pc));
    checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    checkOutput({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    step();
    step();
    checkState("reset", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
    checkOutput("reset.flush_cnt", 64'(flush_cnt), 64'd0);

    // Streaming at full rate
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    step();
    checkState("stream0", 1'b1, 32'hA000_0100, 32'h100, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
    step();
    checkState("stream1", 1'b1, 32'hA000_0104, 32'h104, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    step();
    checkState("stream2", 1'b1, 32'hA000_0108, 32'h108, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkState("drain", 1'b0, NOP, 32'h108, 2'd0, 1'b1);

    // Backpressure into the skid slot
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step();
    checkState("bp0", 1'b1, 32'hA000_0200, 32'h200, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    step();
    checkState("bp1", 1'b1, 32'hA000_0200, 32'h200, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h2FC, 1'b0, 1'b0, 1'b0);
    step();
    checkState("bp_full", 1'b1, 32'hA000_0200, 32'h200, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkState("bp_pop0", 1'b1, 32'hA000_0204, 32'h204, 2'd1, 1'b1);
    step();
    checkState("bp_pop1", 1'b0, NOP, 32'h204, 2'd0, 1'b1);

    // Stall holds the head even with out_ready high
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkState("stall", 1'b1, 32'hA000_0300, 32'h300, 2'd1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkState("unstall", 1'b0, NOP, 32'h300, 2'd0, 1'b1);

    // Flush a full stage while a beat is offered
    applyStimulus(1'b0, 1'b1, 32'h3F0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h3F4, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pre_flush.occupancy", 64'(occupancy), 64'd2);
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
    step();
    checkState("flush", 1'b0, NOP, 32'h3F0, 2'd0, 1'b1);
    checkOutput("flush.flush_cnt", 64'(flush_cnt), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkState("post_flush", 1'b0, NOP, 32'h3F0, 2'd0, 1'b1);

    // Flushing an empty stage is not counted
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("empty_flush.flush_cnt", 64'(flush_cnt), 64'd1);

    // Flush discards a same-cycle accepted push
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h504, 1'b0, 1'b0, 1'b1);
    step();
    checkState("flush_push", 1'b0, NOP, 32'h500, 2'd0, 1'b1);
    checkOutput("flush_push.flush_cnt", 64'(flush_cnt), 64'd2);

    // Flush overrides stall; then saturate the counter
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step();
    checkOutput("stall_flush.occupancy", 64'(occupancy), 64'd0);
    checkOutput("stall_flush.flush_cnt", 64'(flush_cnt), 64'd3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h610 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      checkOutput("saturate.flush_cnt", 64'(flush_cnt), 64'd3);
    end

    // Reset mid-traffic drops the offered beat; first post-reset push is accepted
    applyStimulus(1'b0, 1'b1, 32'h6F0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    step();
    checkState("rst2", 1'b0, NOP, 32'h0, 2'd0, 1'b1);
    checkOutput("rst2.flush_cnt", 64'(flush_cnt), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
    step();
    checkState("post_rst", 1'b1, 32'hA000_0800, 32'h800, 2'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
